shot_traj: RTL and testbench



---
 rtl/shot_pkg.sv | 22 ++
 rtl/shot_x_step.sv | 51 +++++
 rtl/shot_traj.sv | 126 ++++++++++++
 tb/tb_shot_traj.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/shot_pkg.sv
// Shared types and defaults for the shot trajectory stepper.
// SHOT_BOUNCE_EN selects reflecting side walls instead of stopping walls.
package shot_pkg;

  localparam int COORD_W   = 5;
  localparam int X_MAX_D   = 31;
  localparam int Y_MAX_D   = 31;
  localparam int Y_START_D = 0;

  typedef enum logic [1:0] {
    IDLE,
    FLIGHT,
    FINISH
  } state_t;

`ifdef SHOT_BOUNCE_EN
  localparam bit BOUNCE_EN = 1'b1;
`else
  localparam bit BOUNCE_EN = 1'b0;
`endif

endpackage

// File: rtl/shot_x_step.sv
// Combinational horizontal step with side-wall detection.
// SHOT_BOUNCE_EN: reflect off walls; otherwise clamp at the wall.
module shot_x_step
  import shot_pkg::*;
#(
  parameter int X_MAX = X_MAX_D
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] run,
  input  logic               dir,
  output logic [COORD_W-1:0] next_x,
  output logic               next_dir,
  output logic               wall_hit
);

  logic [COORD_W:0] sum;
  logic [COORD_W:0] xmax;

  assign sum  = {1'b0, x} + {1'b0, run};
  assign xmax = (COORD_W+1)'(X_MAX);

  always_comb begin
    next_x   = x;
    next_dir = dir;
    wall_hit = 1'b0;
    unique case (1'b1)
      (!dir && (x < run)): begin
        wall_hit = 1'b1;
`ifdef SHOT_BOUNCE_EN
        next_x   = run - x;
        next_dir = 1'b1;
`else
        next_x   = '0;
`endif
      end
      (dir && (sum > xmax)): begin
        wall_hit = 1'b1;
`ifdef SHOT_BOUNCE_EN
        next_x   = COORD_W'((COORD_W+1)'(2*X_MAX) - sum);
        next_dir = 1'b0;
`else
        next_x   = COORD_W'(X_MAX);
`endif
      end
      default: begin
        next_x = dir ? sum[COORD_W-1:0] : x - run;
      end
    endcase
  end

endmodule

// File: rtl/shot_traj.sv
// Shot trajectory stepper: latches aim on fire, steps per tick.
// Wall behaviour follows SHOT_BOUNCE_EN (see shot_x_step).
module shot_traj
  import shot_pkg::*;
#(
  parameter int X_MAX   = X_MAX_D,
  parameter int Y_MAX   = Y_MAX_D,
  parameter int Y_START = Y_START_D
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               fire,
  input  logic               stop,
  input  logic [COORD_W-1:0] x_pos,
  input  logic [COORD_W-1:0] run,
  input  logic [COORD_W-1:0] rise,
  input  logic               dir,
  output logic               active,
  output logic [COORD_W-1:0] shot_x,
  output logic [COORD_W-1:0] shot_y,
  output logic               done,
  output logic               wall
);

  state_t               state_q, state_d;
  logic [COORD_W-1:0]   run_q, run_d;
  logic [COORD_W-1:0]   rise_q, rise_d;
  logic                 dir_q, dir_d;
  logic                 active_d, done_d, wall_d;
  logic [COORD_W-1:0]   x_d, y_d;
  logic [COORD_W-1:0]   step_x;
  logic                 step_dir, step_wall;
  logic [COORD_W:0]     y_sum;
  logic                 y_top;

  shot_x_step #(.X_MAX(X_MAX)) u_x_step (
    .x        (shot_x),
    .run      (run_q),
    .dir      (dir_q),
    .next_x   (step_x),
    .next_dir (step_dir),
    .wall_hit (step_wall)
  );

  assign y_sum = {1'b0, shot_y} + {1'b0, rise_q};
  assign y_top = (y_sum >= (COORD_W+1)'(Y_MAX));

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    rise_d   = rise_q;
    dir_d    = dir_q;
    active_d = active;
    x_d      = shot_x;
    y_d      = shot_y;
    done_d   = 1'b0;
    wall_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          state_d  = FLIGHT;
          x_d      = x_pos;
          y_d      = COORD_W'(Y_START);
          run_d    = run;
          rise_d   = rise;
          dir_d    = dir;
          active_d = 1'b1;
        end
      end
      FLIGHT: begin
        if (stop) begin
          state_d  = IDLE;
          active_d = 1'b0;
        end else if (tick) begin
          x_d    = step_x;
          dir_d  = step_dir;
          wall_d = step_wall;
          y_d    = y_top ? COORD_W'(Y_MAX)
                         : y_sum[COORD_W-1:0];
          // Reaching the top still completes the shot
          if (y_top) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else if (step_wall && !BOUNCE_EN) begin
            state_d  = IDLE;
            active_d = 1'b0;
          end
        end
      end
      FINISH: begin
        state_d  = IDLE;
        active_d = 1'b0;
      end
      default: begin
        state_d  = IDLE;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      run_q   <= '0;
      rise_q  <= '0;
      dir_q   <= 1'b0;
      active  <= 1'b0;
      shot_x  <= '0;
      shot_y  <= '0;
      done    <= 1'b0;
      wall    <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      rise_q  <= rise_d;
      dir_q   <= dir_d;
      active  <= active_d;
      shot_x  <= x_d;
      shot_y  <= y_d;
      done    <= done_d;
      wall    <= wall_d;
    end
  end

endmodule

// File: tb/tb_shot_traj.sv
// Bench for shot_traj: directed scenarios plus random stimulus
// against a cycle-level behavioural model of the shot.
module tb_shot_traj;

`ifdef SHOT_BOUNCE_EN
  localparam bit BOUNCE = 1'b1;
`else
  localparam bit BOUNCE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       fire = 1'b0;
  logic       stop = 1'b0;
  logic       dir = 1'b0;
  logic [4:0] x_pos = '0;
  logic [4:0] run = '0;
  logic [4:0] rise = '0;
  logic       active, done, wall;
  logic [4:0] shot_x, shot_y;

  int n_chk = 0;
  int n_err = 0;

  int m_act, m_x, m_y, m_done, m_wall;
  int m_run, m_rise, m_dir;
  bit m_fly, m_fin;

  always #5 clk = ~clk;

  shot_traj dut (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .fire   (fire),
    .stop   (stop),
    .x_pos  (x_pos),
    .run    (run),
    .rise   (rise),
    .dir    (dir),
    .active (active),
    .shot_x (shot_x),
    .shot_y (shot_y),
    .done   (done),
    .wall   (wall)
  );

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic void model_step();
    int nx, ny;
    bit hit, fin;
    if (!reset) begin
      m_act = 0; m_x = 0; m_y = 0;
      m_done = 0; m_wall = 0;
      m_run = 0; m_rise = 0; m_dir = 0;
      m_fly = 0; m_fin = 0;
      return;
    end
    m_done = 0;
    m_wall = 0;
    if (m_fin) begin
      m_fin = 0;
      m_act = 0;
    end else if (m_fly) begin
      if (stop) begin
        m_fly = 0;
        m_act = 0;
      end else if (tick) begin
        ny  = m_y + m_rise;
        fin = (ny >= 31);
        if (fin) ny = 31;
        nx  = m_dir ? m_x + m_run : m_x - m_run;
        hit = 0;
        if (nx < 0) begin
          hit = 1;
          nx  = BOUNCE ? -nx : 0;
          if (BOUNCE) m_dir = 1;
        end else if (nx > 31) begin
          hit = 1;
          nx  = BOUNCE ? 62 - nx : 31;
          if (BOUNCE) m_dir = 0;
        end
        m_x = nx;
        m_y = ny;
        m_wall = hit;
        if (fin) begin
          m_fly = 0; m_fin = 1; m_done = 1;
        end else if (hit && !BOUNCE) begin
          m_fly = 0; m_act = 0;
        end
      end
    end else if (fire) begin
      m_fly = 1; m_act = 1;
      m_x = x_pos; m_y = 0;
      m_run = run; m_rise = rise; m_dir = dir;
    end
  endfunction

  task automatic cmp_all(string tag);
    check({tag, ".active"}, 32'(active), 32'(m_act));
    check({tag, ".x"}, 32'(shot_x), 32'(m_x));
    check({tag, ".y"}, 32'(shot_y), 32'(m_y));
    check({tag, ".done"}, 32'(done), 32'(m_done));
    check({tag, ".wall"}, 32'(wall), 32'(m_wall));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    cmp_all("step");
  endtask

  task automatic launch(int xp, int rn, int rs, bit d);
    fire = 1; tick = 0; stop = 0;
    x_pos = 5'(xp); run = 5'(rn); rise = 5'(rs); dir = d;
    step();
    fire = 0;
  endtask

  initial begin
    reset = 0;
    step();
    step();
    check("rst_active", 32'(active), 0);
    check("rst_x", 32'(shot_x), 0);
    check("rst_y", 32'(shot_y), 0);
    reset = 1;

    // Straight up, run=0
    launch(10, 0, 1, 0);
    check("s1_act", 32'(active), 1);
    check("s1_x0", 32'(shot_x), 10);
    check("s1_y0", 32'(shot_y), 0);
    tick = 1;
    repeat (30) step();
    check("s1_y30", 32'(shot_y), 30);
    check("s1_x30", 32'(shot_x), 10);
    step();
    check("s1_y31", 32'(shot_y), 31);
    check("s1_done", 32'(done), 1);
    check("s1_act31", 32'(active), 1);
    tick = 0;
    step();
    check("s1_act_off", 32'(active), 0);
    check("s1_done_off", 32'(done), 0);

    // Latched aim ignores mid-flight input changes
    launch(16, 1, 2, 1);
    x_pos = 3; dir = 0; run = 2; rise = 1;
    tick = 1;
    repeat (15) step();
    check("s2_x15", 32'(shot_x), 31);
    check("s2_y15", 32'(shot_y), 30);
    step();
    check("s2_y16", 32'(shot_y), 31);
    check("s2_done", 32'(done), 1);
    tick = 0;
    step();

    // Side wall on the first step
    launch(1, 2, 1, 0);
    tick = 1;
    step();
    check("s3_wall", 32'(wall), 1);
    check("s3_x", 32'(shot_x), BOUNCE ? 1 : 0);
    check("s3_act", 32'(active), BOUNCE ? 1 : 0);
    step();
    check("s3_x2", 32'(shot_x), BOUNCE ? 3 : 0);
    check("s3_wall2", 32'(wall), 0);
    tick = 0; stop = 1;
    step();
    stop = 0;

    // stop wins over tick, then relaunch
    launch(5, 0, 1, 1);
    tick = 1;
    repeat (7) step();
    stop = 1;
    step();
    check("s4_x", 32'(shot_x), 5);
    check("s4_y", 32'(shot_y), 7);
    check("s4_act", 32'(active), 0);
    check("s4_done", 32'(done), 0);
    stop = 0; tick = 0;
    launch(9, 1, 1, 0);
    check("s4_relaunch", 32'(active), 1);
    check("s4_rel_x", 32'(shot_x), 9);

    // fire held through flight and finish
    stop = 1; step(); stop = 0;
    fire = 1; x_pos = 8; run = 0; rise = 2; dir = 1;
    tick = 1;
    repeat (24) step();
    fire = 0; tick = 0;

    // Reset: glitch between edges, then at an edge
    launch(20, 1, 1, 0);
    tick = 1;
    repeat (3) step();
    reset = 0;
    #2;
    cmp_all("glitch");
    reset = 1;
    step();
    reset = 0;
    step();
    check("rst2_act", 32'(active), 0);
    check("rst2_y", 32'(shot_y), 0);
    reset = 1;

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(199) != 0);
      fire  = ($urandom_range(3) == 0);
      tick  = ($urandom_range(1) == 1);
      stop  = ($urandom_range(49) == 0);
      x_pos = 5'($urandom_range(31));
      run   = 5'($urandom_range(2));
      rise  = 5'($urandom_range(2, 1));
      dir   = ($urandom_range(1) == 1);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
